branch_resolver: RTL

Multi-cycle branch/jump resolution unit in the processor datapath (FD). It takes the six comparison flags produced by the ALU for a control-transfer instruction and decodes them against funct3 to decide taken/not-taken. It computes the next PC and any misalignment or illegal-encoding condition. It hands the result to the PC-update logic over a valid/ready handshake.

---
 rtl/branch_if.sv | 32 +++
 rtl/branch_resolver.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/branch_if.sv
// Request/result handshake between the execute stage, branch_resolver and the PC-update logic.
// master = execute/PC side, slave = branch_resolver.
interface branch_if #(parameter int unsigned XLEN = 64);
    logic            valid_in;
    logic            ready_out;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic [2:0]      funct3;
    logic [5:0]      flags;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic            valid_out;
    logic            ready_in;
    logic            taken;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] link_pc;
    logic            misaligned;
    logic            illegal;
    logic            flush;

    modport master (
        output valid_in, is_branch, is_jal, is_jalr, funct3, flags, pc, imm, rs1, ready_in, flush,
        input  ready_out, valid_out, taken, next_pc, link_pc, misaligned, illegal
    );

    modport slave (
        input  valid_in, is_branch, is_jal, is_jalr, funct3, flags, pc, imm, rs1, ready_in, flush,
        output ready_out, valid_out, taken, next_pc, link_pc, misaligned, illegal
    );
endinterface

// File: rtl/branch_resolver.sv
// Multi-cycle branch/jump resolver: IDLE -> RESOLVE -> DONE with valid/ready result hand-off.
// Optional BRANCH_STATS_EN adds saturating resolved/taken counters.
module branch_resolver #(
    parameter int unsigned XLEN = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    branch_if.slave     bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] stat_resolved,
    output logic [31:0] stat_taken
`endif
);
    localparam int unsigned INSN_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t          state;
    logic            cap_branch;
    logic            cap_jal;
    logic            cap_jalr;
    logic [2:0]      cap_funct3;
    logic [5:0]      cap_flags;
    logic [XLEN-1:0] cap_pc;
    logic [XLEN-1:0] cap_imm;
    logic [XLEN-1:0] cap_rs1;

    logic            cond_c;
    logic            bad_f3_c;
    logic            illegal_c;
    logic            taken_c;
    logic [XLEN-1:0] sum_c;
    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] link_c;

    // Branch condition select; 010/011 are reserved encodings
    always_comb begin
        cond_c   = 1'b0;
        bad_f3_c = 1'b0;
        case (cap_funct3)
            3'b000:  cond_c = cap_flags[0];
            3'b001:  cond_c = cap_flags[1];
            3'b100:  cond_c = cap_flags[2];
            3'b101:  cond_c = cap_flags[3];
            3'b110:  cond_c = cap_flags[4];
            3'b111:  cond_c = cap_flags[5];
            default: bad_f3_c = 1'b1;
        endcase
    end

    // One shared adder: JALR adds to rs1, everything else to pc
    assign sum_c     = (cap_jalr ? cap_rs1 : cap_pc) + cap_imm;
    assign target_c  = {sum_c[XLEN-1:1], sum_c[0] & ~cap_jalr};
    assign link_c    = cap_pc + XLEN'(INSN_BYTES);
    assign illegal_c = (cap_branch & bad_f3_c) | ~(cap_branch | cap_jal | cap_jalr);
    assign taken_c   = cap_jal | cap_jalr | (cap_branch & cond_c);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.ready_out  <= 1'b0;
            bus.valid_out  <= 1'b0;
            bus.taken      <= 1'b0;
            bus.next_pc    <= '0;
            bus.link_pc    <= '0;
            bus.misaligned <= 1'b0;
            bus.illegal    <= 1'b0;
            cap_branch     <= 1'b0;
            cap_jal        <= 1'b0;
            cap_jalr       <= 1'b0;
            cap_funct3     <= '0;
            cap_flags      <= '0;
            cap_pc         <= '0;
            cap_imm        <= '0;
            cap_rs1        <= '0;
        end else if (bus.flush) begin
            // Flush beats a same-cycle request and drops whatever is in flight
            state         <= IDLE;
            bus.ready_out <= 1'b1;
            bus.valid_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.ready_out <= 1'b1;
                    if (bus.valid_in && bus.ready_out) begin
                        cap_branch    <= bus.is_branch;
                        cap_jal       <= bus.is_jal;
                        cap_jalr      <= bus.is_jalr;
                        cap_funct3    <= bus.funct3;
                        cap_flags     <= bus.flags;
                        cap_pc        <= bus.pc;
                        cap_imm       <= bus.imm;
                        cap_rs1       <= bus.rs1;
                        bus.ready_out <= 1'b0;
                        state         <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    bus.taken      <= taken_c;
                    bus.next_pc    <= taken_c ? target_c : link_c;
                    bus.link_pc    <= link_c;
                    bus.misaligned <= taken_c & (target_c[1:0] != 2'b00);
                    bus.illegal    <= illegal_c;
                    bus.valid_out  <= 1'b1;
                    state          <= DONE;
                end
                DONE: begin
                    if (bus.ready_in) begin
                        bus.valid_out <= 1'b0;
                        bus.ready_out <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.valid_out <= 1'b0;
                    bus.ready_out <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic hs_c;
    assign hs_c = bus.valid_out & bus.ready_in;

    // Saturating counters; flush does not touch them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_resolved <= '0;
            stat_taken    <= '0;
        end else if (hs_c) begin
            if (stat_resolved != 32'hFFFF_FFFF) stat_resolved <= stat_resolved + 32'd1;
            if (bus.taken && (stat_taken != 32'hFFFF_FFFF)) stat_taken <= stat_taken + 32'd1;
        end
    end
`endif
endmodule
